// File: rtl/fanout_fork_ctrl.sv
// Single-word eager fork: holds one source word until every routed consumer has taken it.
// Held word is visible one cycle after capture; the source is stalled while any selected consumer is still pending.
module fanout_fork_ctrl #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 17,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NUM_OUT-1:0] cfg_en,
  input  logic [NUM_OUT-1:0] cfg_sel,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [NUM_OUT-1:0] pending;
  logic [NUM_OUT-1:0] active;
  logic [NUM_OUT-1:0] stuck;
  logic               last;
  logic               take;
  logic               stall;

  assign active = cfg_en & cfg_sel;
  // Consumers that still hold the word after this cycle.
  assign stuck  = pending & ~out_ready;

  assign busy      = (state == BUSY);
  assign last      = busy && (stuck == '0);
  assign in_ready  = rst_n && !flush && ((state == IDLE) || last);
  assign take      = in_valid && in_ready;
  assign out_valid = busy ? pending : '0;
  assign stall     = busy && (stuck != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_data  <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (flush) begin
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: begin
            // A word with no route is accepted and dropped here.
            if (take && (active != '0)) begin
              out_data <= in_data;
              pending  <= active;
              state    <= BUSY;
            end
          end
          BUSY: begin
            if (last) begin
              if (take && (active != '0)) begin
                out_data <= in_data;
                pending  <= active;
              end else begin
                pending <= '0;
                state   <= IDLE;
              end
            end else begin
              pending <= stuck;
            end
          end
          default: begin
            state   <= IDLE;
            pending <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed bench for fanout_fork_ctrl: broadcast, staggered accept, back-to-back, no route, cfg change, flush/reset.
module tb_fanout_fork_ctrl;
  localparam int NUM_OUT = 6;
  localparam int DATA_W  = 17;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [NUM_OUT-1:0] cfg_en;
  logic [NUM_OUT-1:0] cfg_sel;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [NUM_OUT-1:0] out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_ready;
  logic               busy;
  logic [CNT_W-1:0]   stall_cnt;

  int tests = 0;
  int fails = 0;

  int                hs   [NUM_OUT];
  logic [DATA_W-1:0] logd [NUM_OUT][32];
  int                base [NUM_OUT];

  fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NUM_OUT; i++) hs[i] = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          logd[i][hs[i] & 31] <= out_data;
          hs[i] <= hs[i] + 1;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < NUM_OUT; i++) base[i] = hs[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; cfg_en = '0; cfg_sel = '0;
    in_valid = 1'b0; in_data = '0; out_ready = '0;
    cycle(); cycle();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (out_valid !== 6'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 17'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (stall_cnt !== 16'h0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_broadcast();
    snap();
    cfg_en = 6'b001111; cfg_sel = 6'b110111; out_ready = 6'b111111;
    in_valid = 1'b1; in_data = 17'h0A5;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t1_in_ready_idle got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 6'b000111) begin fails++; $display("FAIL t1_out_valid got %b want 000111", out_valid); end
    tests++; if (out_data !== 17'h0A5) begin fails++; $display("FAIL t1_out_data got %h want 0a5", out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t1_in_ready_busy got %b want 1", in_ready); end
    cycle();
    tests++; if (busy !== 1'b0 || out_valid !== 6'b0) begin fails++; $display("FAIL t1_done got busy=%b ov=%b want 0/0", busy, out_valid); end
    for (int i = 0; i < NUM_OUT; i++) begin
      tests++;
      if (hs[i] - base[i] !== ((i < 3) ? 1 : 0)) begin
        fails++; $display("FAIL t1_handshakes[%0d] got %0d want %0d", i, hs[i] - base[i], (i < 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_staggered();
    logic [NUM_OUT-1:0] rdy [6];
    logic [NUM_OUT-1:0] pv  [6];
    rdy = '{6'b0, 6'b000001, 6'b000001, 6'b000011, 6'b000011, 6'b000111};
    pv  = '{6'b0, 6'b000111, 6'b000110, 6'b000110, 6'b000100, 6'b000100};
    snap();
    out_ready = 6'b0; in_valid = 1'b1; in_data = 17'h1B2;
    cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      out_ready = rdy[c];
      #1;
      tests++;
      if (in_ready !== (c == 5)) begin
        fails++; $display("FAIL t2_in_ready_c%0d got %b want %b", c, in_ready, (c == 5));
      end
      tests++;
      if (out_valid !== pv[c]) begin
        fails++; $display("FAIL t2_out_valid_c%0d got %b want %b", c, out_valid, pv[c]);
      end
      cycle();
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t2_busy_after got %b want 0", busy); end
    tests++; if (stall_cnt !== 16'd4) begin fails++; $display("FAIL t2_stall_cnt got %0d want 4", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (hs[i] - base[i] !== 1) begin fails++; $display("FAIL t2_handshakes[%0d] got %0d want 1", i, hs[i] - base[i]); end
    end
  endtask

  task automatic test_back_to_back();
    snap();
    out_ready = 6'b111111;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = DATA_W'(k);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t3_in_ready_w%0d got %b want 1", k, in_ready); end
      if (k > 1) begin
        tests++;
        if (out_data !== DATA_W'(k - 1) || out_valid !== 6'b000111) begin
          fails++; $display("FAIL t3_hold_w%0d got %h/%b want %h/000111", k, out_data, out_valid, k - 1);
        end
      end
      cycle();
    end
    in_valid = 1'b0;
    #1;
    tests++; if (out_data !== 17'd4) begin fails++; $display("FAIL t3_last_data got %h want 4", out_data); end
    cycle();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t3_busy_after got %b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (hs[i] - base[i] !== 4) begin fails++; $display("FAIL t3_count[%0d] got %0d want 4", i, hs[i] - base[i]); end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (logd[i][(base[i] + k) & 31] !== DATA_W'(k + 1)) begin
          fails++; $display("FAIL t3_order[%0d][%0d] got %h want %h", i, k, logd[i][(base[i] + k) & 31], k + 1);
        end
      end
    end
  endtask

  task automatic test_no_route();
    cfg_en = 6'b0; cfg_sel = 6'b111111;
    in_valid = 1'b1; in_data = 17'h1FF;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t4_in_ready got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || out_valid !== 6'b0) begin fails++; $display("FAIL t4_idle got busy=%b ov=%b want 0/0", busy, out_valid); end
    tests++; if (out_data !== 17'd4) begin fails++; $display("FAIL t4_data_kept got %h want 4", out_data); end
  endtask

  task automatic test_cfg_change();
    snap();
    cfg_en = 6'b111111; cfg_sel = 6'b000011; out_ready = 6'b0;
    in_valid = 1'b1; in_data = 17'h055;
    cycle();
    in_valid = 1'b0; cfg_sel = 6'b110000;
    #1;
    tests++; if (out_valid !== 6'b000011) begin fails++; $display("FAIL t5_out_valid_a got %b want 000011", out_valid); end
    cycle();
    out_ready = 6'b111111; in_valid = 1'b1; in_data = 17'h066;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t5_in_ready got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 6'b110000 || out_data !== 17'h066) begin fails++; $display("FAIL t5_second got %b/%h want 110000/066", out_valid, out_data); end
    cycle();
    for (int i = 0; i < NUM_OUT; i++) begin
      tests++;
      if (hs[i] - base[i] !== ((i == 2 || i == 3) ? 0 : 1)) begin
        fails++; $display("FAIL t5_handshakes[%0d] got %0d want %0d", i, hs[i] - base[i], (i == 2 || i == 3) ? 0 : 1);
      end
    end
    tests++; if (logd[0][base[0] & 31] !== 17'h055) begin fails++; $display("FAIL t5_c0_data got %h want 055", logd[0][base[0] & 31]); end
    tests++; if (logd[4][base[4] & 31] !== 17'h066) begin fails++; $display("FAIL t5_c4_data got %h want 066", logd[4][base[4] & 31]); end
    tests++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL t5_stall_cnt got %0d want 5", stall_cnt); end
  endtask

  task automatic test_flush_reset();
    cfg_en = 6'b111111; cfg_sel = 6'b000101; out_ready = 6'b0;
    in_valid = 1'b1; in_data = 17'h077;
    cycle();
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 6'b000101) begin fails++; $display("FAIL t6_pending got %b want 000101", out_valid); end
    cycle();
    flush = 1'b1; out_ready = 6'b111111; in_valid = 1'b1; in_data = 17'h123;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t6_flush_in_ready got %b want 0", in_ready); end
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 6'b0;
    #1;
    tests++; if (busy !== 1'b0 || out_valid !== 6'b0) begin fails++; $display("FAIL t6_flush_idle got busy=%b ov=%b want 0/0", busy, out_valid); end
    tests++; if (stall_cnt !== 16'd6) begin fails++; $display("FAIL t6_flush_stall got %0d want 6", stall_cnt); end
    tests++; if (out_data !== 17'h077) begin fails++; $display("FAIL t6_flush_data got %h want 077", out_data); end
    in_valid = 1'b1; in_data = 17'h088;
    cycle();
    in_valid = 1'b0;
    #1;
    tests++; if (busy !== 1'b1 || out_data !== 17'h088) begin fails++; $display("FAIL t6_recapture got %b/%h want 1/088", busy, out_data); end
    rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t6_rst_in_ready got %b want 0", in_ready); end
    cycle();
    rst_n = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || out_valid !== 6'b0) begin fails++; $display("FAIL t6_rst_idle got busy=%b ov=%b want 0/0", busy, out_valid); end
    tests++; if (out_data !== 17'h0 || stall_cnt !== 16'h0) begin fails++; $display("FAIL t6_rst_clear got %h/%0d want 0/0", out_data, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_staggered();
    test_back_to_back();
    test_no_route();
    test_cfg_change();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
